// File: rtl/wb_pkg.sv
// Shared Wishbone widths and arbiter FSM state encodings.
package wb_pkg;
  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 16;
  localparam int WB_SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_ABORT = 2'd2
  } wb_state_e;
endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester after the one-hot last winner, circularly.
module wb_rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [N-1:0] i_last,
  output logic [N-1:0] o_grant
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] w_last_idx;
  logic [IW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    w_last_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (i_last[i]) w_last_idx = IW'(i);
    end
  end

  // Offset N wraps back to the last winner itself, so a lone requester can win again.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = IW'((int'(w_last_idx) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter/mux sharing one slave bus between NUM_MASTERS masters.
// Define WB_ARB_TIMEOUT_EN to add the stalled-cycle timeout (error pulse, ABORT state, fault_o).
module wb_rr_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_MASTERS   = 2,
  parameter int TIMEOUT_WIDTH = 5
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [WB_SEL_W*NUM_MASTERS-1:0] m_sel_i,
  input  logic [WB_ADR_W*NUM_MASTERS-1:0] m_adr_i,
  input  logic [WB_DAT_W*NUM_MASTERS-1:0] m_dat_i,
  output logic [WB_DAT_W-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [NUM_MASTERS-1:0]          m_err_o,
  output logic                            s_cyc_o,
  output logic                            s_stb_o,
  output logic                            s_we_o,
  output logic [WB_SEL_W-1:0]             s_sel_o,
  output logic [WB_ADR_W-1:0]             s_adr_o,
  output logic [WB_DAT_W-1:0]             s_dat_o,
  input  logic                            s_ack_i,
  input  logic                            s_err_i,
  input  logic [WB_DAT_W-1:0]             s_dat_i,
  output logic [NUM_MASTERS-1:0]          grant_o,
  output logic                            fault_o,
  output wb_state_e                       dbg_state_o
);
  localparam int N = NUM_MASTERS;

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_WIDTH < 1) begin : g_bad_cfg
    $error("wb_rr_arbiter: unsupported NUM_MASTERS/TIMEOUT_WIDTH");
  end

  wb_state_e     r_state, w_state_nxt;
  logic [N-1:0]  r_grant, w_grant_nxt;
  logic [N-1:0]  r_last, w_last_nxt;
  logic [N-1:0]  w_pick;
  logic          w_in_own;
  logic          w_timeout;
  logic          w_own_cyc, w_own_stb, w_own_we;
  logic [WB_SEL_W-1:0] w_own_sel;
  logic [WB_ADR_W-1:0] w_own_adr;
  logic [WB_DAT_W-1:0] w_own_dat;

  wb_rr_pick #(.N(N)) u_pick (
    .i_req   (m_cyc_i),
    .i_last  (r_last),
    .o_grant (w_pick)
  );

  // r_grant is one-hot or zero, so an OR-mux selects the owner's signals.
  always_comb begin
    w_own_cyc = 1'b0;
    w_own_stb = 1'b0;
    w_own_we  = 1'b0;
    w_own_sel = '0;
    w_own_adr = '0;
    w_own_dat = '0;
    for (int k = 0; k < N; k++) begin
      if (r_grant[k]) begin
        w_own_cyc = m_cyc_i[k];
        w_own_stb = m_stb_i[k];
        w_own_we  = m_we_i[k];
        w_own_sel = m_sel_i[k*WB_SEL_W +: WB_SEL_W];
        w_own_adr = m_adr_i[k*WB_ADR_W +: WB_ADR_W];
        w_own_dat = m_dat_i[k*WB_DAT_W +: WB_DAT_W];
      end
    end
  end

  // Handshake: a master holds cyc for its whole tenure; a transfer completes in any OWN
  // cycle where stb is high and the slave answers with ack or err (no wait on our side).
  assign w_in_own = (r_state == ST_OWN);
  assign s_cyc_o  = w_in_own & w_own_cyc;
  assign s_stb_o  = w_in_own & w_own_stb;
  assign s_we_o   = w_in_own & w_own_we;
  assign s_sel_o  = w_in_own ? w_own_sel : '0;
  assign s_adr_o  = w_in_own ? w_own_adr : '0;
  assign s_dat_o  = w_in_own ? w_own_dat : '0;
  assign m_dat_o  = s_dat_i;
  assign m_ack_o  = r_grant & {N{s_ack_i & s_stb_o}};
  assign m_err_o  = r_grant & {N{(s_err_i & s_stb_o) | w_timeout}};
  assign grant_o  = r_grant;
  assign dbg_state_o = r_state;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          w_state_nxt = ST_OWN;
          w_grant_nxt = w_pick;
        end
      end
      ST_OWN, ST_ABORT: begin
        if (!w_own_cyc) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_last_nxt  = r_grant;
        end else if (r_state == ST_OWN && w_timeout) begin
          w_state_nxt = ST_ABORT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last  <= {1'b1, {(N-1){1'b0}}};
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] r_cnt;
  logic                     r_fault;
  logic                     w_grant_evt;

  assign w_grant_evt = (r_state == ST_IDLE) & (|m_cyc_i);
  assign w_timeout   = s_stb_o & ~s_ack_i & ~s_err_i & (&r_cnt);
  assign fault_o     = r_fault;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      if (w_grant_evt || s_ack_i || s_err_i) r_cnt <= '0;
      else if (s_stb_o && !(&r_cnt))         r_cnt <= r_cnt + 1'b1;
      if (w_grant_evt)    r_fault <= 1'b0;
      else if (w_timeout) r_fault <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign fault_o   = 1'b0;
`endif
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed scenarios plus a randomized run against a
// cycle-level ownership model. Build with WB_ARB_TIMEOUT_EN to exercise the timeout path.
module tb_wb_rr_arbiter;
  import wb_pkg::*;

  localparam int N    = 2;
  localparam int TW   = 5;
  localparam int TMAX = (1 << TW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [2*N-1:0]  m_sel;
  logic [32*N-1:0] m_adr;
  logic [16*N-1:0] m_dat;
  logic [15:0]     m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [1:0]      s_sel_o;
  logic [31:0]     s_adr_o;
  logic [15:0]     s_dat_o;
  logic            s_ack, s_err;
  logic [15:0]     s_dat;
  logic [N-1:0]    grant_o;
  logic            fault_o;
  wb_state_e       dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: owner index (-1 = nobody), last owner, stalled-strobe count, abort and fault flags.
  int mdl_owner = -1;
  int mdl_last  = N - 1;
  int mdl_stall = 0;
  bit mdl_abort = 1'b0;
  bit mdl_fault = 1'b0;

  wb_rr_arbiter #(.NUM_MASTERS(N), .TIMEOUT_WIDTH(TW)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_dat_i(s_dat),
    .grant_o(grant_o), .fault_o(fault_o), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within 2 ms");
    $fatal(1);
  end

  function automatic logic [N-1:0] onehot(int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic bit mdl_in_own();
    return (mdl_owner >= 0) && !mdl_abort;
  endfunction

  function automatic bit mdl_stb();
    if (!mdl_in_own()) return 1'b0;
    return m_stb[mdl_owner];
  endfunction

  function automatic bit mdl_timeout_now();
`ifdef WB_ARB_TIMEOUT_EN
    return mdl_stb() && !s_ack && !s_err && (mdl_stall == TMAX);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    mdl_owner = -1;
    mdl_last  = N - 1;
    mdl_stall = 0;
    mdl_abort = 1'b0;
    mdl_fault = 1'b0;
  endtask

  task automatic model_edge();
    bit tmo, stb;
    int c;
    tmo = mdl_timeout_now();
    stb = mdl_stb();
    if (mdl_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        c = (mdl_last + k) % N;
        if (mdl_owner < 0 && m_cyc[c]) mdl_owner = c;
      end
      if (mdl_owner >= 0) begin
        mdl_stall = 0;
        mdl_fault = 1'b0;
        mdl_abort = 1'b0;
      end
    end else if (!m_cyc[mdl_owner]) begin
      mdl_last  = mdl_owner;
      mdl_owner = -1;
      mdl_abort = 1'b0;
    end else if (!mdl_abort) begin
      if (tmo) begin
        mdl_abort = 1'b1;
        mdl_fault = 1'b1;
      end
      if (s_ack || s_err) mdl_stall = 0;
      else if (stb && mdl_stall < TMAX) mdl_stall++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0;
    m_adr = '0; m_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_dat = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    m_cyc = 2'b11; m_stb = 2'b11; m_adr = {32'h2222_0000, 32'h1111_0000};
    #1;
    n_cmp++; if (grant_o !== 2'b00) begin n_bad++; $display("FAIL reset_grant: got %b expected 00", grant_o); end
    n_cmp++; if ({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o} !== 53'd0) begin n_bad++; $display("FAIL reset_sbus: cyc=%b stb=%b adr=%h expected all zero", s_cyc_o, s_stb_o, s_adr_o); end
    n_cmp++; if (fault_o !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b expected 0", fault_o); end
    step();
    n_cmp++; if (grant_o !== 2'b00 || dbg_state !== ST_IDLE) begin n_bad++; $display("FAIL reset_hold: grant=%b state=%0d expected 00/IDLE", grant_o, dbg_state); end
    clear_inputs();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01; m_sel = 4'b0011;
    m_adr[31:0] = 32'h0000_1000; m_dat[15:0] = 16'hBEEF;
    #1;
    n_cmp++; if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL single_latency: grant=%b s_cyc=%b expected 00/0", grant_o, s_cyc_o); end
    step();
    n_cmp++; if (grant_o !== 2'b01) begin n_bad++; $display("FAIL single_grant: got %b expected 01", grant_o); end
    n_cmp++; if (s_cyc_o !== 1'b1 || s_we_o !== 1'b1 || s_adr_o !== 32'h1000 || s_dat_o !== 16'hBEEF) begin n_bad++; $display("FAIL single_bus: cyc=%b we=%b adr=%h dat=%h expected 1/1/00001000/beef", s_cyc_o, s_we_o, s_adr_o, s_dat_o); end
    n_cmp++; if (m_ack_o !== 2'b00) begin n_bad++; $display("FAIL single_noack: got %b expected 00", m_ack_o); end
    step();
    step();
    s_ack = 1'b1; s_dat = 16'h1234;
    #1;
    n_cmp++; if (m_ack_o !== 2'b01 || m_dat_o !== 16'h1234) begin n_bad++; $display("FAIL single_ack: ack=%b dat=%h expected 01/1234", m_ack_o, m_dat_o); end
    step();
    s_ack = 1'b0; m_cyc = 2'b00; m_stb = 2'b00;
    #1;
    n_cmp++; if (m_ack_o !== 2'b00 || s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL single_release: ack=%b s_cyc=%b expected 00/0", m_ack_o, s_cyc_o); end
    step();
    n_cmp++; if (grant_o !== 2'b00) begin n_bad++; $display("FAIL single_idle: got %b expected 00", grant_o); end
    clear_inputs();
  endtask

  task automatic test_contention();
    apply_reset();
    m_cyc = 2'b11; m_stb = 2'b11; m_adr = {32'hB000_0010, 32'hA000_0010};
    step();
    n_cmp++; if (grant_o !== 2'b01 || s_adr_o !== 32'hA000_0010) begin n_bad++; $display("FAIL contention_first: grant=%b adr=%h expected 01/a0000010", grant_o, s_adr_o); end
    step();
    m_cyc = 2'b10;
    step();
    n_cmp++; if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL contention_dead: grant=%b s_cyc=%b expected 00/0", grant_o, s_cyc_o); end
    step();
    n_cmp++; if (grant_o !== 2'b10 || s_adr_o !== 32'hB000_0010) begin n_bad++; $display("FAIL contention_second: grant=%b adr=%h expected 10/b0000010", grant_o, s_adr_o); end
    clear_inputs();
    step();
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_g;
    apply_reset();
    m_cyc = 2'b11; m_stb = 2'b11;
    step();
    for (int r = 0; r < 4; r++) begin
      exp_g = (r % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++; if (grant_o !== exp_g) begin n_bad++; $display("FAIL fairness_round%0d: got %b expected %b", r, grant_o, exp_g); end
      m_cyc = ~exp_g;
      step();
      m_cyc = 2'b11;
      step();
    end
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_burst_hold();
    apply_reset();
    m_cyc = 2'b10; m_stb = 2'b10;
    step();
    m_cyc = 2'b11; m_stb = 2'b11;
    for (int i = 0; i < 4; i++) begin
      m_adr[63:32] = 32'h0000_2000 + 32'(2 * i);
      s_ack = 1'b1;
      #1;
      n_cmp++; if (m_ack_o !== 2'b10 || grant_o !== 2'b10 || s_adr_o !== m_adr[63:32]) begin n_bad++; $display("FAIL burst_ack%0d: ack=%b grant=%b adr=%h expected 10/10/%h", i, m_ack_o, grant_o, s_adr_o, m_adr[63:32]); end
      step();
      s_ack = 1'b0;
      #1;
      n_cmp++; if (m_ack_o !== 2'b00 || grant_o !== 2'b10) begin n_bad++; $display("FAIL burst_gap%0d: ack=%b grant=%b expected 00/10", i, m_ack_o, grant_o); end
      step();
    end
    m_cyc = 2'b01;
    step();
    n_cmp++; if (grant_o !== 2'b00) begin n_bad++; $display("FAIL burst_dead: got %b expected 00", grant_o); end
    step();
    n_cmp++; if (grant_o !== 2'b01) begin n_bad++; $display("FAIL burst_next: got %b expected 01", grant_o); end
    clear_inputs();
    step();
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int err_at;
    err_at = -1;
    apply_reset();
    m_cyc = 2'b10; m_stb = 2'b10;
    step();
    for (int i = 0; i < 40 && err_at < 0; i++) begin
      #1;
      if (m_err_o == 2'b10) err_at = i;
      else step();
    end
    n_cmp++; if (err_at != TMAX) begin n_bad++; $display("FAIL timeout_cycle: error after %0d stalled cycles expected %0d", err_at, TMAX); end
    step();
    n_cmp++; if (fault_o !== 1'b1 || s_cyc_o !== 1'b0 || m_err_o !== 2'b00 || dbg_state !== ST_ABORT) begin n_bad++; $display("FAIL timeout_abort: fault=%b s_cyc=%b err=%b state=%0d expected 1/0/00/ABORT", fault_o, s_cyc_o, m_err_o, dbg_state); end
    step();
    n_cmp++; if (s_cyc_o !== 1'b0 || grant_o !== 2'b10) begin n_bad++; $display("FAIL timeout_hold: s_cyc=%b grant=%b expected 0/10", s_cyc_o, grant_o); end
    m_cyc = 2'b00;
    step();
    n_cmp++; if (grant_o !== 2'b00 || fault_o !== 1'b1) begin n_bad++; $display("FAIL timeout_release: grant=%b fault=%b expected 00/1", grant_o, fault_o); end
    m_cyc = 2'b01;
    step();
    n_cmp++; if (grant_o !== 2'b01 || fault_o !== 1'b0) begin n_bad++; $display("FAIL timeout_regrant: grant=%b fault=%b expected 01/0", grant_o, fault_o); end
    clear_inputs();
    step();
  endtask
`else
  task automatic test_stall();
    int errs;
    errs = 0;
    apply_reset();
    m_cyc = 2'b10; m_stb = 2'b10;
    step();
    for (int i = 0; i < 40; i++) begin
      #1;
      if (m_err_o != 2'b00) errs++;
      step();
    end
    n_cmp++; if (s_cyc_o !== 1'b1 || grant_o !== 2'b10 || fault_o !== 1'b0 || errs != 0) begin n_bad++; $display("FAIL stall_hold: s_cyc=%b grant=%b fault=%b errs=%0d expected 1/10/0/0", s_cyc_o, grant_o, fault_o, errs); end
    clear_inputs();
    step();
  endtask
`endif

  task automatic test_reset_mid();
    apply_reset();
    m_cyc = 2'b01; m_stb = 2'b01;
    step();
    s_ack = 1'b1;
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (s_cyc_o !== 1'b0 || grant_o !== 2'b00 || m_ack_o !== 2'b00) begin n_bad++; $display("FAIL reset_mid_async: s_cyc=%b grant=%b ack=%b expected 0/00/00", s_cyc_o, grant_o, m_ack_o); end
    @(negedge clk);
    clear_inputs();
    m_cyc = 2'b11; m_stb = 2'b11;
    rst = 1'b0;
    step();
    n_cmp++; if (grant_o !== 2'b01) begin n_bad++; $display("FAIL reset_mid_regrant: got %b expected 01", grant_o); end
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_random();
    int o;
    logic [52:0] exp_bus, got_bus;
    logic [N-1:0] exp_ack, exp_err;
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < N; k++) begin
        if (mdl_owner == k) m_cyc[k] = ($urandom_range(0, 9) != 0);
        else                m_cyc[k] = $urandom_range(0, 1) == 1;
        m_stb[k] = $urandom_range(0, 3) != 0;
        m_we[k]  = $urandom_range(0, 1) == 1;
        m_sel[2*k +: 2]   = 2'($urandom_range(0, 3));
        m_adr[32*k +: 32] = $urandom;
        m_dat[16*k +: 16] = 16'($urandom);
      end
      s_ack = $urandom_range(0, 9) < 3;
      s_err = $urandom_range(0, 19) == 0;
      s_dat = 16'($urandom);
      #1;
      o = mdl_owner;
      exp_bus = '0;
      if (mdl_in_own()) exp_bus = {m_cyc[o], m_stb[o], m_we[o], m_sel[2*o +: 2], m_adr[32*o +: 32], m_dat[16*o +: 16]};
      got_bus = {s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o};
      exp_ack = (mdl_stb() && s_ack) ? onehot(o) : '0;
      exp_err = ((mdl_stb() && s_err) || mdl_timeout_now()) ? onehot(o) : '0;
      n_cmp++; if (grant_o !== onehot(o) || fault_o !== mdl_fault) begin n_bad++; $display("FAIL rand_grant@%0d: grant=%b fault=%b expected %b/%b", cyc, grant_o, fault_o, onehot(o), mdl_fault); end
      n_cmp++; if (got_bus !== exp_bus) begin n_bad++; $display("FAIL rand_bus@%0d: got %h expected %h", cyc, got_bus, exp_bus); end
      n_cmp++; if (m_ack_o !== exp_ack || m_err_o !== exp_err) begin n_bad++; $display("FAIL rand_resp@%0d: ack=%b err=%b expected %b/%b", cyc, m_ack_o, m_err_o, exp_ack, exp_err); end
      n_cmp++; if (m_dat_o !== s_dat) begin n_bad++; $display("FAIL rand_rdata@%0d: got %h expected %h", cyc, m_dat_o, s_dat); end
      step();
    end
    clear_inputs();
    step();
    step();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_burst_hold();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_stall();
`endif
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
